timer_sched_ctrl: RTL and testbench
===================================

# timer_sched_ctrl

Programmable interval-timer controller built around a 32-bit reversible count register. It latches a preset, direction and mode on a start command, and advances the count on prescaled ticks. At terminal count it emits a one-cycle pulse and a sticky interrupt. It either reloads automatically (periodic) or stops (one-shot). It sits between the FSM/control layer and the 32-bit counting datapath, sequencing load, count, reload and stop.

## Interface
- PRESC_W, 8, width of the prescaler divide field
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  command: latch config and (re)load count; sampled every cycle
- stop  in  1  command: abort counting and return to IDLE
- hold  in  1  freeze prescaler and count while in RUN
- mode  in  1  0 = one-shot, 1 = periodic; latched on start
- dir  in  1  1 = count up, 0 = count down; latched on start
- preset  in  32  load value; latched on start
- presc  in  PRESC_W  tick every presc+1 cycles; latched on start
- irq_ack  in  1  clears irq
- cnt  out  32  current count (registered)
- busy  out  1  1 while in RUN
- tc  out  1  one-cycle terminal-count pulse (registered)
- irq  out  1  sticky interrupt, set by tc
- overrun  out  1  sticky: tc occurred while irq still pending

## Operation
- States: IDLE (busy=0) and RUN (busy=1). Internal regs: preset_q, mode_q, dir_q, presc_q, psc (PRESC_W bits).
- start (any state, stop=0): latch preset/mode/dir/presc into the *_q regs, cnt<=preset, psc<=0, overrun<=0, state<=RUN. A start in RUN restarts the timer; no tc is generated.
- stop (in RUN): state<=IDLE, psc<=0, cnt holds, no tc. stop and start in the same cycle: stop wins, start ignored. stop in IDLE has no effect.
- Tick: in RUN with hold=0, psc==presc_q gives a tick and psc<=0; otherwise psc<=psc+1. hold=1 freezes both psc and cnt.
- On a non-terminal tick: cnt<=cnt+1 (dir_q=1) or cnt-1 (dir_q=0).
- Terminal tick: tick with cnt==32'h0000_0000 (down) or cnt==32'hFFFF_FFFF (up). On a terminal tick, tc<=1 for one cycle.
  - Periodic: cnt<=preset_q and the timer stays in RUN.
  - One-shot: cnt holds the terminal value and state<=IDLE.
- Counting never wraps silently; every boundary crossing is a terminal event.
- irq: set on tc. Cleared by irq_ack when no tc occurs in the same cycle. tc with irq_ack in the same cycle leaves irq=1 with no overrun.
- overrun: set when tc occurs while irq=1 and irq_ack=0. Cleared only by start or reset.

## Timing
- Reset (async, rst_n=0): state IDLE; cnt, busy, tc, irq, overrun, psc and all *_q regs = 0.
- start sampled at edge E0: after E0, cnt=preset and busy=1.
- With presc=p, the first count change occurs at edge E0+(p+1). Ticks then follow every p+1 cycles.
- Down count from P: terminal tick is the (P+1)th tick. tc, irq and (one-shot) busy=0 become visible after edge E0+(P+1)(p+1).
- Up count from P: terminal tick is the (2^32−P)th tick.
- Periodic period: exactly (P+1)(p+1) cycles (down). Reload adds no dead cycle.
- Outputs are all registered; there is no combinational path from input to output.
- hold asserted for h cycles delays every subsequent event by exactly h cycles.

## Test plan
- Reset mid-RUN: assert rst_n=0 while cnt=5 -> all outputs 0 immediately (async), state IDLE, restart behaves as if fresh.
- One-shot down: preset=3, presc=0, dir=0, mode=0, start at E0 -> cnt 3,2,1,0 after E0..E3; tc=1, irq=1, busy=0 after E4; cnt stays 0; tc=0 after E5.
- Periodic down with prescaler: preset=2, presc=1 -> tc pulses every 6 cycles; cnt sequence 2,2,1,1,0,0,2…; ack each irq -> overrun stays 0.
- Up wrap: preset=32'hFFFF_FFFE, dir=1, presc=0, mode=1 -> cnt FFFF_FFFF after E1, tc after E2 with cnt=FFFF_FFFE (reload).
- Overrun and ack: periodic preset=0, presc=0, irq never acked -> tc every cycle, overrun=1 after the second tc. irq_ack coincident with tc -> irq stays 1, no overrun. start clears overrun.
- Commands: hold 3 cycles mid-count delays tc by 3. Restart in RUN reloads with no tc. stop+start in the same cycle -> IDLE, cnt unchanged.

Source files
------------

// File: rtl/timer_sched_if.sv
// Command/status bundle between the control layer and the interval timer.
// The master drives commands and configuration; the slave (timer) returns count and status.
interface timer_sched_if #(
  parameter int PRESC_W = 8
);
  logic               start;
  logic               stop;
  logic               hold;
  logic               mode;
  logic               dir;
  logic [31:0]        preset;
  logic [PRESC_W-1:0] presc;
  logic               irq_ack;
  logic [31:0]        cnt;
  logic               busy;
  logic               tc;
  logic               irq;
  logic               overrun;

  modport master (
    output start, stop, hold, mode, dir, preset, presc, irq_ack,
    input  cnt, busy, tc, irq, overrun
  );

  modport slave (
    input  start, stop, hold, mode, dir, preset, presc, irq_ack,
    output cnt, busy, tc, irq, overrun
  );
endinterface

// File: rtl/timer_sched_ctrl.sv
// Programmable interval timer: 32-bit up/down count on prescaled ticks,
// one-shot or periodic reload, terminal-count pulse, sticky irq and overrun.
module timer_sched_ctrl #(
  parameter int PRESC_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  timer_sched_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [31:0]        r_cnt;
  logic [31:0]        r_preset_q;
  logic               r_mode_q;
  logic               r_dir_q;
  logic [PRESC_W-1:0] r_presc_q;
  logic [PRESC_W-1:0] r_psc;
  logic               r_tc;
  logic               r_irq;
  logic               r_ovr;

  logic w_run;
  logic w_start;
  logic w_stop;
  logic w_tick;
  logic w_at_end;
  logic w_term;

  assign w_run    = (r_state == ST_RUN);
  // stop always beats start, even in IDLE where stop itself does nothing
  assign w_start  = bus.start & ~bus.stop;
  assign w_stop   = bus.stop & w_run;
  // a command in the same cycle pre-empts the tick, so restart/abort never emit tc
  assign w_tick   = w_run & ~bus.start & ~bus.stop & ~bus.hold & (r_psc == r_presc_q);
  assign w_at_end = r_dir_q ? (r_cnt == 32'hFFFF_FFFF) : (r_cnt == 32'h0000_0000);
  assign w_term   = w_tick & w_at_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_preset_q <= '0;
      r_mode_q   <= 1'b0;
      r_dir_q    <= 1'b0;
      r_presc_q  <= '0;
      r_psc      <= '0;
      r_tc       <= 1'b0;
      r_irq      <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_tc <= w_term;

      if (w_start) begin
        r_preset_q <= bus.preset;
        r_mode_q   <= bus.mode;
        r_dir_q    <= bus.dir;
        r_presc_q  <= bus.presc;
        r_cnt      <= bus.preset;
        r_psc      <= '0;
        r_state    <= ST_RUN;
      end else if (w_stop) begin
        r_state <= ST_IDLE;
        r_psc   <= '0;
      end else if (w_run && !bus.hold) begin
        if (w_tick) begin
          r_psc <= '0;
          if (w_term) begin
            // periodic reload lands on the terminal edge itself: no dead cycle
            if (r_mode_q) begin
              r_cnt <= r_preset_q;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (r_dir_q) begin
            r_cnt <= r_cnt + 32'd1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end else begin
          r_psc <= r_psc + 1'b1;
        end
      end

      if (w_term) begin
        r_irq <= 1'b1;
      end else if (bus.irq_ack) begin
        r_irq <= 1'b0;
      end

      // start and a terminal tick are mutually exclusive, so at most one branch fires
      if (w_start) begin
        r_ovr <= 1'b0;
      end else if (w_term && r_irq && !bus.irq_ack) begin
        r_ovr <= 1'b1;
      end
    end
  end

  assign bus.cnt     = r_cnt;
  assign bus.busy    = w_run;
  assign bus.tc      = r_tc;
  assign bus.irq     = r_irq;
  assign bus.overrun = r_ovr;

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Directed bench for timer_sched_ctrl: a per-cycle vector table plus
// hand-written hold and asynchronous-reset sequences.
module tb_timer_sched_ctrl;

  logic clk;
  logic rst_n;

  timer_sched_if #(.PRESC_W(8)) bus ();

  timer_sched_ctrl #(.PRESC_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        hold;
    logic        mode;
    logic        dir;
    logic [31:0] preset;
    logic [7:0]  presc;
    logic        ack;
    logic [31:0] e_cnt;
    logic        e_busy;
    logic        e_tc;
    logic        e_irq;
    logic        e_ovr;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic add(input logic st, input logic sp, input logic hd, input logic md,
                     input logic dr, input logic [31:0] pr, input logic [7:0] ps,
                     input logic ak, input logic [31:0] ec, input logic eb,
                     input logic et, input logic ei, input logic eo);
    vec_t v;
    v.start = st; v.stop = sp; v.hold = hd; v.mode = md; v.dir = dr;
    v.preset = pr; v.presc = ps; v.ack = ak;
    v.e_cnt = ec; v.e_busy = eb; v.e_tc = et; v.e_irq = ei; v.e_ovr = eo;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic st, input logic sp, input logic hd, input logic md,
                       input logic dr, input logic [31:0] pr, input logic [7:0] ps,
                       input logic ak);
    bus.start = st; bus.stop = sp; bus.hold = hd; bus.mode = md; bus.dir = dr;
    bus.preset = pr; bus.presc = ps; bus.irq_ack = ak;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // packed view {cnt, busy, tc, irq, overrun}
  task automatic check_out(input string name, input logic [35:0] exp_v);
    logic [35:0] act_v;
    act_v = {bus.cnt, bus.busy, bus.tc, bus.irq, bus.overrun};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got cnt=%h busy=%b tc=%b irq=%b ovr=%b, want cnt=%h busy=%b tc=%b irq=%b ovr=%b",
               name, act_v[35:4], act_v[3], act_v[2], act_v[1], act_v[0],
               exp_v[35:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end else begin
      $display("ok   %s: cnt=%h busy=%b tc=%b irq=%b ovr=%b",
               name, act_v[35:4], act_v[3], act_v[2], act_v[1], act_v[0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  initial begin
    int cyc;
    int found;

    drive(0, 0, 0, 0, 0, 32'h0, 8'h0, 0);
    rst_n = 1'b0;

    //  st sp hd md dr preset         presc ack   cnt           b  tc irq ovr
    // one-shot down from 3
    add(1, 0, 0, 0, 0, 32'd3,         8'd0, 0,    32'd3,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd2,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd1,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 1,    32'd0,        0, 0, 0, 0);
    // periodic down from 2, presc=1: 2,2,1,1,0,0,2...
    add(1, 0, 0, 1, 0, 32'd2,         8'd1, 0,    32'd2,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd2,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd1,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd1,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd2,        1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 1,    32'd2,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd1,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd1,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd2,        1, 1, 1, 0);
    add(0, 1, 0, 0, 0, 32'd0,         8'd0, 0,    32'd2,        0, 0, 1, 0);
    // up count across the top, periodic
    add(1, 0, 0, 1, 1, 32'hFFFF_FFFE, 8'd0, 0,    32'hFFFF_FFFE, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 1,    32'hFFFF_FFFF, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'hFFFF_FFFE, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'hFFFF_FFFF, 1, 0, 1, 0);
    add(0, 1, 0, 0, 0, 32'd0,         8'd0, 0,    32'hFFFF_FFFF, 0, 0, 1, 0);
    // periodic preset=0: tc every cycle, overrun, coincident ack, start clears overrun
    add(1, 0, 0, 1, 0, 32'd0,         8'd0, 1,    32'd0,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 1, 1, 1);
    add(1, 0, 0, 1, 0, 32'd0,         8'd0, 1,    32'd0,        1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 1,    32'd0,        1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        1, 1, 1, 1);
    add(0, 1, 0, 0, 0, 32'd0,         8'd0, 0,    32'd0,        0, 0, 1, 1);
    // restart in RUN, stop+start, stop in IDLE
    add(1, 0, 0, 0, 0, 32'd5,         8'd0, 0,    32'd5,        1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd4,        1, 0, 1, 0);
    add(1, 0, 0, 0, 0, 32'd10,        8'd0, 0,    32'd10,       1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'd0,         8'd0, 0,    32'd9,        1, 0, 1, 0);
    add(1, 1, 0, 0, 0, 32'd7,         8'd0, 0,    32'd9,        0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 32'd0,         8'd0, 0,    32'd9,        0, 0, 1, 0);

    step();
    step();
    check_out("reset_state", 36'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].hold, vecs[i].mode, vecs[i].dir,
            vecs[i].preset, vecs[i].presc, vecs[i].ack);
      step();
      check_out($sformatf("vec%0d", i),
                {vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_tc, vecs[i].e_irq, vecs[i].e_ovr});
    end
    drive(0, 0, 0, 0, 0, 32'h0, 8'h0, 0);

    // hold for 3 cycles mid-count: one-shot down from 2 ends 3 cycles late
    drive(1, 0, 0, 0, 0, 32'd2, 8'd0, 1);
    step();
    check_out("hold_start", {32'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    drive(0, 0, 0, 0, 0, 32'h0, 8'h0, 0);
    step();
    bus.hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      step();
      check_out($sformatf("hold_frozen%0d", h), {32'd1, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    bus.hold = 1'b0;
    cyc = 4;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step();
      cyc++;
      if (bus.tc) found = 1;
    end
    check_int("hold_tc_seen", found, 1);
    check_int("hold_tc_cycle", cyc, 6);
    check_out("hold_tc_state", {32'd0, 1'b0, 1'b1, 1'b1, 1'b0});

    // asynchronous reset while running at cnt=5
    drive(1, 0, 0, 0, 0, 32'd10, 8'd0, 0);
    step();
    drive(0, 0, 0, 0, 0, 32'h0, 8'h0, 0);
    for (int k = 0; k < 5; k++) step();
    check_out("pre_reset", {32'd5, 1'b1, 1'b0, 1'b1, 1'b0});
    #2 rst_n = 1'b0;
    #1;
    check_out("async_reset", 36'h0);
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 32'd2, 8'd0, 0);
    step();
    check_out("post_reset_start", {32'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    drive(0, 0, 0, 0, 0, 32'h0, 8'h0, 0);
    cyc = 0;
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step();
      cyc++;
      if (bus.tc) found = 1;
    end
    check_int("post_reset_tc_seen", found, 1);
    check_int("post_reset_tc_cycle", cyc, 3);
    check_out("post_reset_tc_state", {32'd0, 1'b0, 1'b1, 1'b1, 1'b0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
